contrast_stretching_mc: RTL and testbench
=========================================

// Module: contrast_stretching_mc
// PURPOSE
//  Parametrised multi-channel successor to the single-channel contrast stretcher. Buffers one frame of
//  CHANNELS packed pixels, tracks per-channel min/max during load, computes a per-channel fixed-point
//  scale with a shared sequential divider, then streams out pixels remapped to a programmable range
//  [cfg_lo, cfg_hi]. Sits between the frame source (camera/RAM loader) and the VGA/output RAM writer.
// PARAMETERS
//  DATA_WIDTH  8      bits per channel sample
//  CHANNELS    1      channels packed per pixel (1 = gray, 3 = RGB)
//  RAM_DEPTH   76800  pixels per frame (320x240)
//  ADDR_WIDTH  $clog2(RAM_DEPTH)  frame buffer address width
//  FRAC_BITS   16     fractional bits of the scale factor
// PORTS
//  clk_i_contrast_mc   in   1                   clock, all logic on rising edge
//  rstn_i_contrast_mc  in   1                   synchronous active-low reset
//  en_i_contrast_mc    in   1                   frame enable; low aborts to IDLE
//  cfg_lo_i            in   DATA_WIDTH          output range low, sampled on IDLE->LOAD
//  cfg_hi_i            in   DATA_WIDTH          output range high, sampled on IDLE->LOAD
//  valid_i             in   1                   input pixel valid
//  ready_o             out  1                   high only in LOAD
//  data_i              in   CHANNELS*DATA_WIDTH input pixel, channel 0 in LSBs
//  valid_o             out  1                   output pixel valid
//  ready_i             in   1                   downstream accept
//  data_o              out  CHANNELS*DATA_WIDTH stretched pixel
//  done_process_o      out  1                   one-cycle pulse on CALC->STREAM
//  done_o              out  1                   level, high in DONE
// BEHAVIOUR
//  Reset: state=IDLE; ready_o, valid_o, done_process_o, done_o = 0; data_o = 0; min regs all-ones, max 0.
//  FSM IDLE->LOAD on en high (latch cfg, clear addr/min/max). LOAD: each valid_i&ready_o writes RAM[addr],
//   updates per-channel min/max, addr++; after RAM_DEPTH writes -> CALC (ready_o low same edge).
//  CALC: per channel c sequentially, restoring divider, DATA_WIDTH+FRAC_BITS cycles each:
//   scale[c] = ((cfg_hi-cfg_lo) << FRAC_BITS) / (max[c]-min[c]), truncated, width DATA_WIDTH+FRAC_BITS.
//   max[c]==min[c] or cfg_hi<=cfg_lo: divider skipped for c, scale[c]=0. Then STREAM, pulse done_process_o.
//  STREAM: read RAM addr 0..RAM_DEPTH-1 in order; pipeline: RAM read (1 cyc) -> multiply -> output reg.
//   Per channel: y = cfg_lo + min(cfg_hi-cfg_lo, ((p-min[c])*scale[c] + 2^(FRAC_BITS-1)) >> FRAC_BITS).
//   First valid_o no later than 3 cycles after entering STREAM with ready_i high; then 1 pixel/cycle.
//  Backpressure: valid_o&!ready_i holds data_o stable; read addr and pipeline stall (or skid); no pixel
//   lost/duplicated. Transfer counted on valid_o&ready_i; after RAM_DEPTH transfers -> DONE.
//  DONE: done_o=1, valid_o=0; stays until en low -> IDLE. New frame needs en low then high.
//  en low in LOAD/CALC/STREAM: next edge IDLE, valid_o/ready_o/done_* cleared, partial frame discarded.
//  Reset mid-operation: identical to power-on reset. valid_i ignored outside LOAD.
// TESTING
//  T1 CH=1,DEPTH=4, px 50,100,150,200, lo=0 hi=255 -> 0,85,170,255; done_process_o one pulse.
//  T2 flat frame all 77, lo=10 hi=200 -> every output 10; CALC skips divider.
//  T3 CH=1, px 0,128,255,0, lo=16 hi=235 -> 16,126,235,16.
//  T4 CH=3,DEPTH=4, ch0 as T1, ch1 all 9, ch2 0,255,0,255, lo=0 hi=255 -> ch0 0,85,170,255; ch1 0; ch2 unchanged.
//  T5 T1 frame with ready_i random 50% -> same 4 values in order, data_o stable while stalled, then done_o.
//  T6 en dropped after 2 of 4 loads -> IDLE next cycle, outputs 0; rerun T1 -> T1 results exactly.

Source files
------------

// File: rtl/contrast_stretching_mc.sv
`default_nettype none
// ============================================================================
//  Module      : contrast_stretching_mc
//  Description : Multi-channel frame contrast stretcher. Buffers one frame,
//                tracks per-channel min/max while loading, derives a
//                per-channel fixed-point scale with one shared restoring
//                divider, then streams every pixel remapped to [lo, hi].
//  Revision    : 1.0  initial release
// ============================================================================
module contrast_stretching_mc #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int RAM_DEPTH  = 76800,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int FRAC_BITS  = 16
) (
  input  logic                           clk_i_contrast_mc,
  input  logic                           rstn_i_contrast_mc,
  input  logic                           en_i_contrast_mc,
  input  logic [DATA_WIDTH-1:0]          cfg_lo_i,
  input  logic [DATA_WIDTH-1:0]          cfg_hi_i,
  input  logic                           valid_i,
  output logic                           ready_o,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
  output logic                           valid_o,
  input  logic                           ready_i,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_o,
  output logic                           done_process_o,
  output logic                           done_o
);

  localparam int c_PIX_W  = CHANNELS * DATA_WIDTH;
  localparam int c_Q_W    = DATA_WIDTH + FRAC_BITS;
  localparam int c_CNT_W  = ADDR_WIDTH + 1;
  localparam int c_CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int c_DIVC_W = $clog2(c_Q_W) + 1;
  localparam int c_PROD_W = DATA_WIDTH + c_Q_W + 1;
  localparam int c_INT_W  = c_PROD_W - FRAC_BITS;

  localparam logic [c_CNT_W-1:0]  c_LAST_PIX = c_CNT_W'(RAM_DEPTH - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_DIVC_W-1:0] c_DIV_LAST = c_DIVC_W'(c_Q_W - 1);
  localparam logic [c_DIVC_W-1:0] c_DIV_ONE  = c_DIVC_W'(1);
  localparam logic [c_CH_W-1:0]   c_LAST_CH  = c_CH_W'(CHANNELS - 1);
  localparam logic [c_CH_W-1:0]   c_CH_ONE   = c_CH_W'(1);
  localparam logic [c_PROD_W-1:0] c_ROUND    = c_PROD_W'(1) << (FRAC_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_STREAM = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Frame buffer and per-frame configuration / statistics
  logic [c_PIX_W-1:0]    r_mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] r_lo;
  logic [DATA_WIDTH-1:0] r_range;
  logic [DATA_WIDTH-1:0] r_min [CHANNELS];
  logic [DATA_WIDTH-1:0] r_max [CHANNELS];
  logic [c_Q_W-1:0]      r_scale [CHANNELS];
  logic [c_CNT_W-1:0]    r_wr_addr;

  // Shared divider
  logic [c_CH_W-1:0]     r_ch;
  logic                  r_div_busy;
  logic [c_DIVC_W-1:0]   r_div_cnt;
  logic [c_Q_W-1:0]      r_div_q;
  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] w_div_d;
  logic                  w_skip;
  logic [DATA_WIDTH:0]   w_trial;
  logic [DATA_WIDTH:0]   w_sub;
  logic                  w_qbit;
  logic                  w_ch_done;
  logic                  w_calc_finish;

  // Stream pipeline
  logic [c_CNT_W-1:0]    r_rd_addr;
  logic [c_CNT_W-1:0]    r_xfer_cnt;
  logic [c_PIX_W-1:0]    r_rd_data;
  logic                  r_s1_valid;
  logic                  r_valid_o;
  logic [c_PIX_W-1:0]    r_data_o;
  logic                  r_done_process;
  logic [c_PIX_W-1:0]    w_stretched;
  logic                  w_wr_fire;
  logic                  w_xfer;
  logic                  w_adv;
  logic                  w_issue;
  logic                  w_stream_run;

  assign w_wr_fire    = valid_i && (r_state == S_LOAD);
  assign w_xfer       = r_valid_o && ready_i;
  assign w_adv        = !r_valid_o || ready_i;
  assign w_issue      = (r_rd_addr <= c_LAST_PIX);
  assign w_stream_run = (r_state == S_STREAM) && (w_state_next == S_STREAM);

  assign valid_o        = r_valid_o;
  assign data_o         = r_data_o;
  assign done_process_o = r_done_process;

  // Divider datapath: one restoring step per cycle on the current channel
  assign w_div_d = r_max[r_ch] - r_min[r_ch];
  assign w_skip  = (w_div_d == '0) || (r_range == '0);
  assign w_trial = {r_rem, r_div_q[c_Q_W-1]};
  assign w_sub   = w_trial - {1'b0, w_div_d};
  assign w_qbit  = ~w_sub[DATA_WIDTH];

  assign w_ch_done     = (r_state == S_CALC) &&
                         (r_div_busy ? (r_div_cnt == c_DIV_LAST) : w_skip);
  assign w_calc_finish = w_ch_done && (r_ch == c_LAST_CH);

  // State register
  always_ff @(posedge clk_i_contrast_mc) begin
    if (!rstn_i_contrast_mc) r_state <= S_IDLE;
    else                     r_state <= w_state_next;
  end

  // Next-state decode and state-level outputs; en low aborts any active state
  always_comb begin
    w_state_next = r_state;
    ready_o      = 1'b0;
    done_o       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en_i_contrast_mc) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        ready_o = 1'b1;
        if (!en_i_contrast_mc)                          w_state_next = S_IDLE;
        else if (w_wr_fire && r_wr_addr == c_LAST_PIX) w_state_next = S_CALC;
      end
      S_CALC: begin
        if (!en_i_contrast_mc)  w_state_next = S_IDLE;
        else if (w_calc_finish) w_state_next = S_STREAM;
      end
      S_STREAM: begin
        if (!en_i_contrast_mc)                       w_state_next = S_IDLE;
        else if (w_xfer && r_xfer_cnt == c_LAST_PIX) w_state_next = S_DONE;
      end
      S_DONE: begin
        done_o = 1'b1;
        if (!en_i_contrast_mc) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Latch output range at frame start, then accumulate per-channel min/max
  always_ff @(posedge clk_i_contrast_mc) begin
    if (!rstn_i_contrast_mc) begin
      r_lo      <= '0;
      r_range   <= '0;
      r_wr_addr <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_min[c] <= '1;
        r_max[c] <= '0;
      end
    end else if (r_state == S_IDLE && en_i_contrast_mc) begin
      r_lo      <= cfg_lo_i;
      r_range   <= (cfg_hi_i > cfg_lo_i) ? (cfg_hi_i - cfg_lo_i) : '0;
      r_wr_addr <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_min[c] <= '1;
        r_max[c] <= '0;
      end
    end else if (w_wr_fire) begin
      r_wr_addr <= r_wr_addr + c_CNT_ONE;
      for (int c = 0; c < CHANNELS; c++) begin
        if (data_i[c*DATA_WIDTH +: DATA_WIDTH] < r_min[c])
          r_min[c] <= data_i[c*DATA_WIDTH +: DATA_WIDTH];
        if (data_i[c*DATA_WIDTH +: DATA_WIDTH] > r_max[c])
          r_max[c] <= data_i[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Frame buffer: written during load, read in order while streaming
  always_ff @(posedge clk_i_contrast_mc) begin
    if (w_wr_fire)
      r_mem[r_wr_addr[ADDR_WIDTH-1:0]] <= data_i;
    if (w_stream_run && w_adv && w_issue)
      r_rd_data <= r_mem[r_rd_addr[ADDR_WIDTH-1:0]];
  end

  // Sequential per-channel scale computation; flat channels bypass the divider
  always_ff @(posedge clk_i_contrast_mc) begin
    if (!rstn_i_contrast_mc) begin
      r_ch       <= '0;
      r_div_busy <= 1'b0;
      r_div_cnt  <= '0;
      r_div_q    <= '0;
      r_rem      <= '0;
      for (int c = 0; c < CHANNELS; c++) r_scale[c] <= '0;
    end else if (r_state != S_CALC) begin
      r_ch       <= '0;
      r_div_busy <= 1'b0;
      r_div_cnt  <= '0;
    end else if (!r_div_busy) begin
      if (w_skip) begin
        r_scale[r_ch] <= '0;
        r_ch          <= r_ch + c_CH_ONE;
      end else begin
        r_div_q    <= {r_range, {FRAC_BITS{1'b0}}};
        r_rem      <= '0;
        r_div_cnt  <= '0;
        r_div_busy <= 1'b1;
      end
    end else begin
      r_rem     <= w_qbit ? w_sub[DATA_WIDTH-1:0] : w_trial[DATA_WIDTH-1:0];
      r_div_q   <= {r_div_q[c_Q_W-2:0], w_qbit};
      r_div_cnt <= r_div_cnt + c_DIV_ONE;
      if (r_div_cnt == c_DIV_LAST) begin
        r_scale[r_ch] <= {r_div_q[c_Q_W-2:0], w_qbit};
        r_div_busy    <= 1'b0;
        r_ch          <= r_ch + c_CH_ONE;
      end
    end
  end

  // Per-channel remap: round((p-min)*scale), clamp to range, offset by lo
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DATA_WIDTH-1:0] w_pix;
    logic [DATA_WIDTH-1:0] w_diff;
    logic [DATA_WIDTH-1:0] w_clamp;
    logic [c_PROD_W-1:0]   w_prod;
    logic [c_INT_W-1:0]    w_int;
    logic                  w_unused_frac;

    assign w_pix         = r_rd_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_diff        = w_pix - r_min[g];
    assign w_prod        = c_PROD_W'(w_diff) * c_PROD_W'(r_scale[g]) + c_ROUND;
    assign w_int         = w_prod[c_PROD_W-1:FRAC_BITS];
    assign w_unused_frac = ^w_prod[FRAC_BITS-1:0];
    assign w_clamp       = (w_int > c_INT_W'(r_range)) ? r_range
                                                       : w_int[DATA_WIDTH-1:0];
    assign w_stretched[g*DATA_WIDTH +: DATA_WIDTH] = r_lo + w_clamp;
  end

  // Two-stage stream pipeline (RAM read, remap into output register); the
  // whole pipeline freezes while the output is offered but not accepted
  always_ff @(posedge clk_i_contrast_mc) begin
    if (!rstn_i_contrast_mc) begin
      r_rd_addr  <= '0;
      r_xfer_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_valid_o  <= 1'b0;
      r_data_o   <= '0;
    end else if (!w_stream_run) begin
      r_rd_addr  <= '0;
      r_xfer_cnt <= '0;
      r_s1_valid <= 1'b0;
      r_valid_o  <= 1'b0;
      r_data_o   <= '0;
    end else begin
      if (w_xfer) r_xfer_cnt <= r_xfer_cnt + c_CNT_ONE;
      if (w_adv) begin
        r_valid_o <= r_s1_valid;
        if (r_s1_valid) r_data_o <= w_stretched;
        r_s1_valid <= w_issue;
        if (w_issue) r_rd_addr <= r_rd_addr + c_CNT_ONE;
      end
    end
  end

  // One-cycle pulse marking the end of scale computation
  always_ff @(posedge clk_i_contrast_mc) begin
    if (!rstn_i_contrast_mc) r_done_process <= 1'b0;
    else r_done_process <= (r_state == S_CALC) && (w_state_next == S_STREAM);
  end

endmodule
`default_nettype wire

// File: tb/tb_contrast_stretching_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contrast_stretching_mc
//  Description : Self-checking bench. A gray (1-channel) and an RGB
//                (3-channel) instance run the same frames side by side; the
//                gray instance sees channel 0 only. Expected pixels come
//                from an arithmetic model of the stretch rule.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_contrast_stretching_mc;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [7:0]  lo;
  logic [7:0]  hi;
  logic        valid_i;
  logic        ready_i;
  logic [23:0] din;

  logic [1:0]  rdy;
  logic [1:0]  vo;
  logic [1:0]  dproc;
  logic [1:0]  done;
  logic [7:0]  d1;
  logic [23:0] d3;
  logic [23:0] dout [2];

  int checks = 0;
  int errors = 0;

  logic [23:0] frame [DEPTH];
  logic [23:0] expq  [DEPTH];

  always #5 clk = ~clk;

  assign dout[0] = {16'h0, d1};
  assign dout[1] = d3;

  contrast_stretching_mc #(
    .DATA_WIDTH(8), .CHANNELS(1), .RAM_DEPTH(DEPTH), .FRAC_BITS(16)
  ) u_dut1 (
    .clk_i_contrast_mc (clk),
    .rstn_i_contrast_mc(rstn),
    .en_i_contrast_mc  (en),
    .cfg_lo_i          (lo),
    .cfg_hi_i          (hi),
    .valid_i           (valid_i),
    .ready_o           (rdy[0]),
    .data_i            (din[7:0]),
    .valid_o           (vo[0]),
    .ready_i           (ready_i),
    .data_o            (d1),
    .done_process_o    (dproc[0]),
    .done_o            (done[0])
  );

  contrast_stretching_mc #(
    .DATA_WIDTH(8), .CHANNELS(3), .RAM_DEPTH(DEPTH), .FRAC_BITS(16)
  ) u_dut3 (
    .clk_i_contrast_mc (clk),
    .rstn_i_contrast_mc(rstn),
    .en_i_contrast_mc  (en),
    .cfg_lo_i          (lo),
    .cfg_hi_i          (hi),
    .valid_i           (valid_i),
    .ready_o           (rdy[1]),
    .data_i            (din),
    .valid_o           (vo[1]),
    .ready_i           (ready_i),
    .data_o            (d3),
    .done_process_o    (dproc[1]),
    .done_o            (done[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Stretch rule applied channel by channel to the whole frame
  function automatic void model(input int l, input int h);
    for (int c = 0; c < 3; c++) begin
      int    mn = 255;
      int    mx = 0;
      int    rng;
      longint sc;
      for (int i = 0; i < DEPTH; i++) begin
        int v = int'(frame[i][c*8 +: 8]);
        if (v < mn) mn = v;
        if (v > mx) mx = v;
      end
      rng = (h > l) ? (h - l) : 0;
      if (mx == mn || rng == 0) sc = 0;
      else sc = (longint'(rng) * 65536) / longint'(mx - mn);
      for (int i = 0; i < DEPTH; i++) begin
        longint t = ((longint'(int'(frame[i][c*8 +: 8]) - mn) * sc) + 32768) / 65536;
        if (t > longint'(rng)) t = longint'(rng);
        expq[i][c*8 +: 8] = 8'(l + int'(t));
      end
    end
  endfunction

  task automatic check_idle(input string name);
    for (int l = 0; l < 2; l++) begin
      check($sformatf("%s ready l%0d", name, l), 32'(rdy[l]), 0);
      check($sformatf("%s valid l%0d", name, l), 32'(vo[l]), 0);
      check($sformatf("%s dproc l%0d", name, l), 32'(dproc[l]), 0);
      check($sformatf("%s done l%0d", name, l), 32'(done[l]), 0);
      check($sformatf("%s data l%0d", name, l), 32'(dout[l]), 0);
    end
  endtask

  // Load frame[], stream it out under random backpressure, then release en
  task automatic run_frame(input string name, input logic [7:0] l, input logic [7:0] h,
                           input int ready_pct);
    int k = 0;
    int cyc = 0;
    int idx [2];
    int pulses [2];
    logic stalled [2];
    logic [23:0] held [2];
    for (int i = 0; i < 2; i++) begin
      idx[i] = 0; pulses[i] = 0; stalled[i] = 1'b0; held[i] = '0;
    end
    model(int'(l), int'(h));
    @(negedge clk);
    lo = l; hi = h; en = 1'b1; valid_i = 1'b0;
    while (k < DEPTH && cyc < 100) begin
      @(negedge clk);
      cyc++;
      valid_i = 1'b0;
      if (rdy[0] && rdy[1] && $urandom_range(0, 3) != 0) begin
        valid_i = 1'b1;
        din = frame[k];
        k++;
      end
    end
    check({name, " loaded"}, 32'(k), DEPTH);
    @(negedge clk);
    valid_i = 1'b0;
    check({name, " ready low after load l0"}, 32'(rdy[0]), 0);
    check({name, " ready low after load l1"}, 32'(rdy[1]), 0);
    cyc = 0;
    while (!(done[0] && done[1]) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (dproc[i]) pulses[i]++;
        if (stalled[i]) begin
          check($sformatf("%s hold valid l%0d", name, i), 32'(vo[i]), 1);
          check($sformatf("%s hold data l%0d", name, i), 32'(dout[i]), 32'(held[i]));
        end
      end
      ready_i = ($urandom_range(0, 99) < ready_pct);
      valid_i = $urandom_range(0, 1) == 1;
      din     = 24'($urandom);
      for (int i = 0; i < 2; i++) begin
        if (vo[i] && ready_i) begin
          if (idx[i] < DEPTH)
            check($sformatf("%s pix%0d l%0d", name, idx[i], i), 32'(dout[i]),
                  (i == 0) ? 32'(expq[idx[i]][7:0]) : 32'(expq[idx[i]]));
          idx[i]++;
        end
        stalled[i] = vo[i] && !ready_i;
        held[i]    = dout[i];
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s done l%0d", name, i), 32'(done[i]), 1);
      check($sformatf("%s count l%0d", name, i), 32'(idx[i]), DEPTH);
      check($sformatf("%s dproc pulses l%0d", name, i), 32'(pulses[i]), 1);
      check($sformatf("%s valid in done l%0d", name, i), 32'(vo[i]), 0);
    end
    @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    check_idle({name, " after en low"});
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; lo = '0; hi = '0;
    valid_i = 1'b0; ready_i = 1'b1; din = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    // T1 / T4: ch0 ramp, ch1 flat, ch2 extremes
    frame[0] = {8'd0,   8'd9, 8'd50};
    frame[1] = {8'd255, 8'd9, 8'd100};
    frame[2] = {8'd0,   8'd9, 8'd150};
    frame[3] = {8'd255, 8'd9, 8'd200};
    run_frame("T1", 8'd0, 8'd255, 100);
    check("T1 literal p1", 32'(expq[1][7:0]), 85);
    check("T4 literal ch2 p1", 32'(expq[1][23:16]), 255);

    // T2: flat frame
    for (int i = 0; i < DEPTH; i++) frame[i] = {3{8'd77}};
    run_frame("T2", 8'd10, 8'd200, 100);

    // T3
    frame[0] = {3{8'd0}}; frame[1] = {3{8'd128}};
    frame[2] = {3{8'd255}}; frame[3] = {3{8'd0}};
    run_frame("T3", 8'd16, 8'd235, 100);

    // T5: T1 frame under 50% backpressure
    frame[0] = {8'd0,   8'd9, 8'd50};
    frame[1] = {8'd255, 8'd9, 8'd100};
    frame[2] = {8'd0,   8'd9, 8'd150};
    frame[3] = {8'd255, 8'd9, 8'd200};
    run_frame("T5", 8'd0, 8'd255, 50);

    // T6: abort after two loads, then rerun T1
    @(negedge clk);
    lo = 8'd0; hi = 8'd255; en = 1'b1;
    @(negedge clk); valid_i = 1'b1; din = 24'd3;
    @(negedge clk); valid_i = 1'b1; din = 24'd250;
    @(negedge clk); valid_i = 1'b0; en = 1'b0;
    @(negedge clk);
    check_idle("T6 abort");
    run_frame("T6 rerun", 8'd0, 8'd255, 100);

    // Reset in the middle of a frame behaves like power-on reset
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      valid_i = 1'b1; din = 24'($urandom);
    end
    valid_i = 1'b0;
    rstn = 1'b0; en = 1'b0;
    @(negedge clk);
    check_idle("midreset");
    rstn = 1'b1;

    // Randomized frames
    for (int r = 0; r < 6; r++) begin
      int l = $urandom_range(0, 200);
      int h = $urandom_range(l, 255);
      for (int i = 0; i < DEPTH; i++) frame[i] = 24'($urandom);
      if (r == 2) for (int i = 0; i < DEPTH; i++) frame[i][15:8] = 8'd42;
      run_frame($sformatf("R%0d", r), 8'(l), 8'(h), $urandom_range(30, 100));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
